// File: rtl/hash_job_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// hash_job_arbiter_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the hash job arbiter:
//   - default per-beat payload width {head_addr, hash_value_vec, data}
//   - FSM state encoding (IDLE=1'b0, LOCKED=1'b1)
//   - job statistics counter width
//   - wrap-around increment helper for round-robin pointers
// The payload width comes from the engine-wide macros ADDR_WIDTH, HASH_BITS,
// HASH_ISSUE_WIDTH and META_HISTORY_LEN. Fallback values are provided when
// the build does not define them.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef HASH_BITS
`define HASH_BITS 8
`endif
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 2
`endif
`ifndef META_HISTORY_LEN
`define META_HISTORY_LEN 3
`endif

package hash_job_arbiter_pkg;

  localparam int PAYLOAD_W_DEF = `ADDR_WIDTH + `HASH_BITS*`HASH_ISSUE_WIDTH
                               + (`HASH_ISSUE_WIDTH + `META_HISTORY_LEN - 1)*8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int STAT_CNT_W = 32;

  // Next requester index after v, wrapping to 0 after n-1.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hash_job_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick
// ----------------------------------------------------------------------------
// Combinational round-robin selector. Returns the first set bit of req_vec
// scanning upward from ptr, modulo N.
// Ports:
//   req_vec [N]     : request bit per requester
//   ptr     [IDX_W] : highest-priority index (must be < N)
//   found           : at least one request is set
//   idx     [IDX_W] : selected requester (0 when nothing is found)
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_vec,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;

  // Scan offsets from the far end down to 0. The last hit written wins, so
  // the closest requester at or after ptr is selected.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (req_vec[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hash_job_arbiter.sv
`default_nettype none
// ============================================================================
// hash_job_arbiter
// ----------------------------------------------------------------------------
// Packet-level round-robin arbiter placed in front of the pre-hash PE
// scheduler input. A grant is held from the first beat of a job until the
// beat carrying delim is accepted, so jobs never interleave. Beats are
// forwarded through a one-entry registered output stage at full throughput.
// Optional feature macro: HASH_JOB_ARB_STATS_EN adds per-requester
// completed-job counters on stat_job_cnt.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   cfg_enable      : permits new grants (a job in progress always completes)
//   req_valid/payload/delim/ready : per-requester beat interface
//   output_valid/payload/delim/req_id, output_ready : scheduler side
//   busy            : job locked or output register occupied
//   stat_job_cnt    : (HASH_JOB_ARB_STATS_EN only) saturating job counts
// Revision: 1.0 - initial release
// ============================================================================
module hash_job_arbiter
  import hash_job_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int REQ_ID_W  = 1,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  input  logic [NUM_REQ-1:0]             req_delim,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           output_valid,
  output logic [PAYLOAD_W-1:0]           output_payload,
  output logic                           output_delim,
  output logic [REQ_ID_W-1:0]            output_req_id,
  input  logic                           output_ready,
  output logic                           busy
`ifdef HASH_JOB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_CNT_W-1:0]  stat_job_cnt
`endif
);

  arb_state_t          state, state_nxt;
  logic [REQ_ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [REQ_ID_W-1:0] grant_id, grant_id_nxt;
  logic [REQ_ID_W-1:0] sel_id;
  logic [REQ_ID_W-1:0] pick_idx;
  logic                pick_found;
  logic                slot_free;
  logic                grant_en;
  logic                accept;
  logic [PAYLOAD_W-1:0] sel_payload;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (REQ_ID_W)
  ) u_rr_pick (
    .req_vec (req_valid),
    .ptr     (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // The output register can take a new beat if empty or draining this cycle.
  assign slot_free = !output_valid || output_ready;

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_id_nxt = grant_id;
    sel_id       = grant_id;
    grant_en     = 1'b0;
    req_ready    = '0;
    accept       = 1'b0;

    case (state)
      ARB_IDLE: begin
        sel_id   = pick_idx;
        grant_en = cfg_enable && pick_found && slot_free;
      end
      ARB_LOCKED: begin
        // Owner keeps ready even while it has no valid beat (a bubble).
        grant_en = slot_free;
      end
      default: ;
    endcase

    if (grant_en) begin
      req_ready[sel_id] = 1'b1;
    end
    accept = grant_en && req_valid[sel_id];

    if (accept) begin
      if (req_delim[sel_id]) begin
        state_nxt  = ARB_IDLE;
        rr_ptr_nxt = REQ_ID_W'(wrap_inc(int'(sel_id), NUM_REQ));
      end else begin
        state_nxt    = ARB_LOCKED;
        grant_id_nxt = sel_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  // Payload only feeds the output register, never a combinational output.
  assign sel_payload = req_payload[int'(sel_id)*PAYLOAD_W +: PAYLOAD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_valid   <= 1'b0;
      output_payload <= '0;
      output_delim   <= 1'b0;
      output_req_id  <= '0;
    end else if (accept) begin
      output_valid   <= 1'b1;
      output_payload <= sel_payload;
      output_delim   <= req_delim[sel_id];
      output_req_id  <= sel_id;
    end else if (output_ready) begin
      output_valid   <= 1'b0;
    end
  end

  assign busy = (state == ARB_LOCKED) || output_valid;

`ifdef HASH_JOB_ARB_STATS_EN
  logic job_done;
  assign job_done = accept && req_delim[sel_id];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (job_done && (sel_id == REQ_ID_W'(g)) && (cnt != '1)) begin
        cnt <= cnt + STAT_CNT_W'(1);
      end
    end
    assign stat_job_cnt[g*STAT_CNT_W +: STAT_CNT_W] = cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hash_job_arbiter.sv
`default_nettype none
// ============================================================================
// tb_hash_job_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for hash_job_arbiter with three requesters. A job-level
// reference model (lock owner, round-robin pointer, one output slot, job
// counts) is compared against the DUT on every falling edge; directed
// scenarios add literal expectations on grant order and stability.
// Optional feature macro: HASH_JOB_ARB_STATS_EN (connects stat_job_cnt).
// Revision: 1.0 - initial release
// ============================================================================
module tb_hash_job_arbiter;
  import hash_job_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int PW = PAYLOAD_W_DEF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_enable;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_payload;
  logic [N-1:0]    req_delim;
  logic [N-1:0]    req_ready;
  logic            output_valid;
  logic [PW-1:0]   output_payload;
  logic            output_delim;
  logic [IW-1:0]   output_req_id;
  logic            output_ready;
  logic            busy;
`ifdef HASH_JOB_ARB_STATS_EN
  logic [N*32-1:0] stat_job_cnt;
`endif

  always #5 clk = ~clk;

  hash_job_arbiter #(
    .NUM_REQ   (N),
    .REQ_ID_W  (IW),
    .PAYLOAD_W (PW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_enable     (cfg_enable),
    .req_valid      (req_valid),
    .req_payload    (req_payload),
    .req_delim      (req_delim),
    .req_ready      (req_ready),
    .output_valid   (output_valid),
    .output_payload (output_payload),
    .output_delim   (output_delim),
    .output_req_id  (output_req_id),
    .output_ready   (output_ready),
    .busy           (busy)
`ifdef HASH_JOB_ARB_STATS_EN
    ,
    .stat_job_cnt   (stat_job_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Requester job sources.
  int   left [N];
  int   jlen [N];
  int   pos  [N];
  int   ser  [N];
  bit   hold [N];
  logic [N-1:0] acc_vec = '0;

  // Observed drained beats.
  int obs_id[$];
  int obs_cyc[$];

  // Reference model.
  bit            m_locked;
  bit            m_ov;
  bit            m_del;
  int            m_owner;
  int            m_ptr;
  int            m_id;
  logic [PW-1:0] m_pay;
  longint        m_cnt [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    int pick;
    int j;
    bit free;
    logic [N-1:0] exp_rdy;
    cyc_n++;
    acc_vec = req_valid & req_ready;
    if (!rst_n) begin
      m_locked = 0; m_ov = 0; m_del = 0; m_owner = 0; m_ptr = 0; m_id = 0; m_pay = '0;
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
      chk("rst_output_valid", output_valid, 1'b0);
      chk("rst_output_payload", output_payload, '0);
      chk("rst_output_delim", output_delim, 1'b0);
      chk("rst_output_req_id", output_req_id, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_ready", req_ready, '0);
`ifdef HASH_JOB_ARB_STATS_EN
      chk("rst_stat", stat_job_cnt, '0);
`endif
    end else begin
      free = !m_ov || output_ready;
      pick = -1;
      if (m_locked) begin
        if (free) pick = m_owner;
      end else if (cfg_enable && free) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (pick < 0 && req_valid[j]) pick = j;
        end
      end
      exp_rdy = '0;
      if (pick >= 0) exp_rdy[pick] = 1'b1;

      chk("req_ready", req_ready, exp_rdy);
      chk("output_valid", output_valid, m_ov);
      if (m_ov) begin
        chk("output_payload", output_payload, m_pay);
        chk("output_delim", output_delim, m_del);
        chk("output_req_id", output_req_id, m_id);
      end
      chk("busy", busy, m_locked || m_ov);
`ifdef HASH_JOB_ARB_STATS_EN
      for (int r = 0; r < N; r++) chk("stat_job_cnt", stat_job_cnt[r*32 +: 32], m_cnt[r]);
`endif
      if (output_valid && output_ready) begin
        obs_id.push_back(int'(output_req_id));
        obs_cyc.push_back(cyc_n);
      end

      if (pick >= 0 && req_valid[pick]) begin
        m_ov  = 1;
        m_pay = req_payload[pick*PW +: PW];
        m_del = req_delim[pick];
        m_id  = pick;
        if (req_delim[pick]) begin
          m_locked = 0;
          m_ptr    = (pick + 1) % N;
          if (m_cnt[pick] < 64'hFFFF_FFFF) m_cnt[pick]++;
        end else begin
          m_locked = 1;
          m_owner  = pick;
        end
      end else if (output_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      req_valid[r] = (left[r] > 0) && !hold[r];
      req_delim[r] = (jlen[r] > 0) && ((pos[r] % jlen[r]) == jlen[r] - 1);
      req_payload[r*PW +: PW] = PW'({8'(r + 1), 8'(pos[r]), 16'(ser[r]),
                                     8'(r + 1) ^ 8'hA5, 8'(pos[r]) ^ 8'h3C, 16'(ser[r] * 7)});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (acc_vec[r] && left[r] > 0) begin
        left[r]--;
        pos[r]++;
        ser[r]++;
      end
    end
    drive();
  endtask

  task automatic job(input int r, input int beats, input int len);
    left[r] = beats;
    jlen[r] = len;
    pos[r]  = 0;
  endtask

  task automatic run_till_idle(input int maxc);
    int c;
    c = 0;
    while ((left[0] + left[1] + left[2] > 0 || output_valid) && c < maxc) begin
      cyc();
      c++;
    end
    chk("idle_timeout", c < maxc, 1'b1);
  endtask

  task automatic chk_seq(input string name, input string exp, input bit contig);
    chk({name, "_count"}, obs_id.size(), exp.len());
    for (int i = 0; i < exp.len() && i < obs_id.size(); i++) begin
      chk({name, "_id"}, obs_id[i], exp.getc(i) - 8'd48);
      if (contig && i > 0) chk({name, "_gap"}, obs_cyc[i] - obs_cyc[i-1], 1);
    end
  endtask

  logic [PW-1:0] p0;
  logic          d0;
  logic [IW-1:0] i0;

  initial begin
    rst_n        = 1'b0;
    cfg_enable   = 1'b1;
    output_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      left[r] = 0; jlen[r] = 0; pos[r] = 0; ser[r] = 0; hold[r] = 0;
    end
    drive();
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("init_busy", busy, 1'b0);
    chk("init_output_valid", output_valid, 1'b0);
    cyc();

    // Back-to-back 3-beat jobs from requesters 0 and 1.
    obs_id.delete(); obs_cyc.delete();
    job(0, 3, 3); job(1, 3, 3); drive();
    run_till_idle(50);
    chk_seq("b2b", "000111", 1'b1);

    // Lock under contention: requester 0 drops valid mid-job.
    obs_id.delete(); obs_cyc.delete();
    job(0, 4, 4); job(1, 1, 1); drive();
    cyc();
    hold[0] = 1; drive();
    repeat (2) begin
      cyc();
      chk("lock_req_ready1", req_ready[1], 1'b0);
    end
    hold[0] = 0; drive();
    run_till_idle(50);
    chk_seq("lock", "00001", 1'b0);

    // Back-pressure on the output register.
    obs_id.delete(); obs_cyc.delete();
    job(2, 4, 4); drive();
    cyc();
    output_ready = 1'b0;
    chk("bp_output_valid", output_valid, 1'b1);
    p0 = output_payload; d0 = output_delim; i0 = output_req_id;
    repeat (4) begin
      cyc();
      chk("bp_payload_stable", output_payload, p0);
      chk("bp_delim_stable", output_delim, d0);
      chk("bp_id", output_req_id, 2'd2);
      chk("bp_req_ready", req_ready, 3'b000);
    end
    obs_id.delete(); obs_cyc.delete();
    output_ready = 1'b1;
    run_till_idle(50);
    chk_seq("bp", "2222", 1'b1);

    // Enable gating during a locked job.
    obs_id.delete(); obs_cyc.delete();
    job(0, 3, 3); job(1, 2, 2); drive();
    cyc();
    cfg_enable = 1'b0;
    repeat (6) cyc();
    chk("en_job_done", left[0], 0);
    chk("en_req1_pending", left[1], 2);
    chk("en_no_grant_ready", req_ready, 3'b000);
    chk("en_no_grant_ovalid", output_valid, 1'b0);
    cfg_enable = 1'b1;
    run_till_idle(50);
    chk_seq("en", "00011", 1'b0);

    // Reset mid-job.
    job(2, 4, 4); drive();
    cyc();
    cyc();
    chk("pre_rst_output_valid", output_valid, 1'b1);
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) left[r] = 0;
    drive();
    #1;
    chk("rst_async_output_valid", output_valid, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single-beat jobs from all requesters, arbitration restarts at 0.
    obs_id.delete(); obs_cyc.delete();
    for (int r = 0; r < N; r++) job(r, 2, 1);
    drive();
    run_till_idle(50);
    chk_seq("single", "012012", 1'b1);
`ifdef HASH_JOB_ARB_STATS_EN
    chk("stat_final", stat_job_cnt, {32'd2, 32'd2, 32'd2});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
